inst_fetch_queue: RTL and testbench

//  Fetch-block queue between I-cache read port (upstream) and decode (downstream).
//  - Buffers 128-bit fetch blocks (mms_pkg::inst_set_t, 4 x 32-bit insts, 16 B aligned).
//  - Issues one instruction plus its PC per cycle over a valid/ready handshake.
//  - Honours a misaligned fetch start (PC[3:2]) and drops everything on flush_i.

---
 rtl/mms_pkg.sv | 29 ++
 rtl/inst_fetch_queue_slot_sel.sv | 14 +
 rtl/inst_fetch_queue.sv | 151 +++++++++++++++
 tb/tb_inst_fetch_queue.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mms_pkg.sv
// Shared fetch-path types: the 4-instruction fetch block and the fetch-queue entry.
// Provides `DATA_WD and `IFQ_DEPTH defaults used by inst_fetch_queue.
`ifndef DATA_WD
`define DATA_WD 32
`endif
`ifndef IFQ_DEPTH
`define IFQ_DEPTH 4
`endif

package mms_pkg;

    localparam int unsigned INST_WD   = 32;
    localparam int unsigned IFQ_SLOTS = 4;

    // insts[k] is the instruction at block address + 4*k
    typedef logic [IFQ_SLOTS-1:0][INST_WD-1:0] inst_set_t;

    typedef struct packed {
        logic [`DATA_WD-5:0] blk_addr;
        logic [1:0]          start;
        inst_set_t           insts;
    } ifq_entry_t;

    function automatic logic [`DATA_WD-1:0] ifq_pc(input logic [`DATA_WD-5:0] blk_addr,
                                                   input logic [1:0]          slot);
        return {blk_addr, slot, 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_queue_slot_sel.sv
// Selects one 32-bit instruction out of a fetch block by slot index.
module ifq_slot_sel
    import mms_pkg::*;
(
    input  inst_set_t   insts_i,
    input  logic [1:0]  slot_i,
    output logic [31:0] inst_o
);

    always_comb begin
        inst_o = insts_i[slot_i];
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch-block queue between the I-cache and decode; emits one instruction + PC per cycle.
// Optional same-cycle bypass on an empty queue is enabled with `define IFQ_BYPASS_EN.
module inst_fetch_queue
    import mms_pkg::*;
#(
    parameter int DEPTH = `IFQ_DEPTH,
    parameter int PC_WD = `DATA_WD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     ic_valid_i,
    output logic                     ic_ready_o,
    input  logic [PC_WD-1:0]         ic_pc_i,
    input  inst_set_t                ic_inst_i,
    output logic                     dec_valid_o,
    input  logic                     dec_ready_i,
    output logic [31:0]              dec_inst_o,
    output logic [PC_WD-1:0]         dec_pc_o,
    output logic [$clog2(DEPTH):0]   blk_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    ifq_entry_t      mem_q [DEPTH];
    ifq_entry_t      mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   nxt_ptr;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      rd_slot_q, rd_slot_d;

    logic            push, store, q_valid, head_pop, retire;
    logic            byp, byp_take;
    logic [1:0]      in_start, store_start, nxt_start, sel_slot;
    inst_set_t       sel_insts;
    logic [31:0]     sel_inst;
    logic [PC_WD-5:0] head_addr;
    logic [1:0]      unused_pc_lsb;

    assign unused_pc_lsb = ic_pc_i[1:0];

    // One selector serves both the head entry and (when enabled) the bypass block.
    ifq_slot_sel u_slot_sel (
        .insts_i (sel_insts),
        .slot_i  (sel_slot),
        .inst_o  (sel_inst)
    );

    always_comb begin
        in_start   = ic_pc_i[3:2];
        nxt_ptr    = rd_ptr_q + 1'b1;
        nxt_start  = mem_q[nxt_ptr].start;
        head_addr  = mem_q[rd_ptr_q].blk_addr;

        ic_ready_o = !rst && !flush_i && (cnt_q != FULL);
        push       = ic_valid_i && ic_ready_o;
`ifdef IFQ_BYPASS_EN
        byp        = push && (cnt_q == '0);
`else
        byp        = 1'b0;
`endif
        q_valid    = !rst && !flush_i && (cnt_q != '0);
        dec_valid_o = q_valid || byp;
        byp_take   = byp && dec_ready_i;
        head_pop   = q_valid && dec_ready_i;
        retire     = head_pop && (rd_slot_q == 2'd3);

        // A bypassed block whose only slot was just consumed never enters the queue.
        store       = push && !(byp_take && (in_start == 2'd3));
        store_start = in_start + {1'b0, byp_take};

        sel_insts  = byp ? ic_inst_i : mem_q[rd_ptr_q].insts;
        sel_slot   = byp ? in_start  : rd_slot_q;

        dec_inst_o = '0;
        dec_pc_o   = '0;
        if (byp) begin
            dec_inst_o = sel_inst;
            dec_pc_o   = ic_pc_i;
        end else if (q_valid) begin
            dec_inst_o = sel_inst;
            dec_pc_o   = ifq_pc(head_addr, rd_slot_q);
        end

        blk_cnt_o = rst ? '0 : cnt_q;
    end

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        rd_slot_d = rd_slot_q;

        if (flush_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            cnt_d     = '0;
            rd_slot_d = '0;
        end else begin
            if (store) begin
                mem_d[wr_ptr_q].blk_addr = ic_pc_i[PC_WD-1:4];
                mem_d[wr_ptr_q].start    = store_start;
                mem_d[wr_ptr_q].insts    = ic_inst_i;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (retire) begin
                rd_ptr_d = nxt_ptr;
            end
            cnt_d = cnt_q + CW'(store) - CW'(retire);

            // The head slot comes from the next stored entry, or from the incoming
            // block when it is about to become the head of an otherwise empty queue.
            if (retire) begin
                if (cnt_q > CW'(1)) begin
                    rd_slot_d = nxt_start;
                end else if (store) begin
                    rd_slot_d = store_start;
                end else begin
                    rd_slot_d = '0;
                end
            end else if (head_pop) begin
                rd_slot_d = rd_slot_q + 1'b1;
            end else if (store && (cnt_q == '0)) begin
                rd_slot_d = store_start;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rd_slot_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            rd_slot_q <= rd_slot_d;
            mem_q     <= mem_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios then random traffic,
// checked against an instruction-level reference queue.
module tb_inst_fetch_queue;
  import mms_pkg::*;

  localparam int DEPTH = 4;
  localparam int PC_WD = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        ic_valid_i;
  logic        ic_ready_o;
  logic [31:0] ic_pc_i;
  inst_set_t   ic_inst_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_inst_o;
  logic [31:0] dec_pc_o;
  logic [2:0]  blk_cnt_o;

  // Handshake: a block transfers on a rising edge where ic_valid_i && ic_ready_o;
  // an instruction transfers on a rising edge where dec_valid_o && dec_ready_i.

  inst_fetch_queue #(.DEPTH(DEPTH), .PC_WD(PC_WD)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .ic_valid_i  (ic_valid_i),
    .ic_ready_o  (ic_ready_o),
    .ic_pc_i     (ic_pc_i),
    .ic_inst_i   (ic_inst_i),
    .dec_valid_o (dec_valid_o),
    .dec_ready_i (dec_ready_i),
    .dec_inst_o  (dec_inst_o),
    .dec_pc_o    (dec_pc_o),
    .blk_cnt_o   (blk_cnt_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // entry = {block id, instruction, pc}
  logic [95:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;
  int blk_id = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int blocks_held();
    int n;
    n = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == 0 || exp_q[i][95:64] != exp_q[i-1][95:64]) n++;
    end
    return n;
  endfunction

  always @(negedge clk) begin : monitor
    int          held;
    bit          was_empty;
    bit          exp_valid;
    logic [31:0] pc;
    logic [95:0] front;
    if (rst) begin
      chk("rst_ic_ready", 64'(ic_ready_o), 64'd0);
      chk("rst_dec_valid", 64'(dec_valid_o), 64'd0);
      chk("rst_blk_cnt", 64'(blk_cnt_o), 64'd0);
      exp_q.delete();
    end else begin
      held = blocks_held();
      was_empty = (exp_q.size() == 0);
      chk("blk_cnt", 64'(blk_cnt_o), 64'(held));
      chk("ic_ready", 64'(ic_ready_o), 64'(!flush_i && held != DEPTH));
      if (flush_i) begin
        chk("flush_dec_valid", 64'(dec_valid_o), 64'd0);
        exp_q.delete();
      end else begin
        if (ic_valid_i && ic_ready_o) begin
          blk_id++;
          for (int s = int'(ic_pc_i[3:2]); s < 4; s++) begin
            pc = {ic_pc_i[31:4], 4'b0000} + 32'(4 * s);
            exp_q.push_back({32'(blk_id), ic_inst_i[s], pc});
          end
        end
`ifdef IFQ_BYPASS_EN
        exp_valid = (exp_q.size() != 0);
`else
        exp_valid = !was_empty;
`endif
        chk("dec_valid", 64'(dec_valid_o), 64'(exp_valid));
        if (dec_valid_o && exp_q.size() != 0) begin
          front = exp_q[0];
          chk("dec_inst", 64'(dec_inst_o), 64'(front[63:32]));
          chk("dec_pc", 64'(dec_pc_o), 64'(front[31:0]));
          if (dec_ready_i) void'(exp_q.pop_front());
        end else if (!dec_valid_o) begin
          chk("idle_outputs", {dec_inst_o, dec_pc_o}, 64'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_block();
    for (int k = 0; k < 4; k++) ic_inst_i[k] = $urandom;
  endtask

  task automatic send(input logic [31:0] pc);
    bit acc;
    bit done;
    done = 1'b0;
    rand_block();
    ic_pc_i = pc;
    ic_valid_i = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      acc = ic_ready_o;
      tick();
      done = acc;
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
    ic_valid_i = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    dec_ready_i = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = (blk_cnt_o == 0) && !dec_valid_o;
      tick();
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    ic_valid_i = 1'b0;
    dec_ready_i = 1'b0;
    ic_pc_i = '0;
    ic_inst_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(ic_ready_o), 64'd1);
    tick();

    // aligned block, then misaligned block
    dec_ready_i = 1'b1;
    send(32'h0000_1000);
    drain();
    send(32'h0000_2008);
    drain();

    // fill to DEPTH, hold a fifth block until the head retires
    dec_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h0000_5000 + 32'(16 * i));
    fork
      send(32'h0000_5040);
      begin
        repeat (5) tick();
        dec_ready_i = 1'b1;
      end
    join
    drain();

    // flush with a block offered in the same cycle
    dec_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h0000_6000 + 32'(16 * i));
    rand_block();
    ic_pc_i = 32'h0000_7000;
    ic_valid_i = 1'b1;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    ic_valid_i = 1'b0;
    @(negedge clk);
    chk("post_flush_blk_cnt", 64'(blk_cnt_o), 64'd0);
    chk("post_flush_valid", 64'(dec_valid_o), 64'd0);
    tick();
    dec_ready_i = 1'b1;
    send(32'h0000_3000);
    drain();

    // empty queue, start in last slot
    send(32'h0000_400C);
    drain();

    // random traffic with occasional flush and reset
    for (int c = 0; c < 3000; c++) begin
      ic_valid_i = ($urandom_range(0, 2) != 0);
      ic_pc_i = $urandom;
      rand_block();
      dec_ready_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 40) == 0);
      rst = ($urandom_range(0, 300) == 0);
      tick();
    end
    rst = 1'b0;
    flush_i = 1'b0;
    ic_valid_i = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
